// File: rtl/buff_uart_scheduler_if.sv
// Requester-fabric and buffered-UART register-port signals shared by the scheduler.
// The slave modport is the scheduler's view. The master modport is the surrounding fabric and UART.
interface buff_uart_scheduler_if #(
    parameter int width         = 8,
    parameter int address_width = 4,
    parameter int num_req       = 4
);
    logic [num_req-1:0]       req;
    logic [num_req-1:0]       req_write;
    logic [num_req*width-1:0] req_wdata;
    logic [num_req-1:0]       ack;
    logic [width-1:0]         rdata;
    logic                     tx_full;
    logic                     rx_empty;
    logic [address_width-1:0] active_address;
    logic                     write_enable;
    logic                     read_enable;
    logic [width-1:0]         bus_wdata;
    logic [width-1:0]         bus_rdata;
    logic                     busy;

    modport master (
        output req, req_write, req_wdata, tx_full, rx_empty, bus_rdata,
        input  ack, rdata, active_address, write_enable, read_enable, bus_wdata, busy
    );

    modport slave (
        input  req, req_write, req_wdata, tx_full, rx_empty, bus_rdata,
        output ack, rdata, active_address, write_enable, read_enable, bus_wdata, busy
    );
endinterface

// File: rtl/buff_uart_scheduler.sv
// Round-robin scheduler that serialises single-word requester transactions onto one
// buffered-UART register port, skipping requests that the FIFO status says would stall.
module buff_uart_scheduler #(
    parameter int                       width         = 8,
    parameter int                       address_width = 4,
    parameter int                       num_req       = 4,
    parameter logic [address_width-1:0] write_address = 'h1,
    parameter logic [address_width-1:0] read_address  = 'h2,
    parameter logic [address_width-1:0] idle_address  = 'hF,
    parameter int                       read_latency  = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    buff_uart_scheduler_if.slave bus
);
    localparam int iw = $clog2(num_req);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t                   state, state_d;
    logic [iw-1:0]            rr_ptr, winner, pick, idx;
    logic                     op_write, found, issue_d;
    logic [2:0]               lat_cnt;
    logic                     lat_last;
    logic [num_req-1:0]       elig;
    logic [width-1:0]         wdata_arr [num_req];

    logic [num_req-1:0]       ack_q, ack_d;
    logic [width-1:0]         rdata_q, rdata_d, wdata_q, wdata_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic                     we_q, we_d, re_q, re_d, busy_q, busy_d;

    for (genvar i = 0; i < num_req; i++) begin : g_req
        assign wdata_arr[i] = bus.req_wdata[i*width +: width];
        assign elig[i]      = bus.req[i] && (bus.req_write[i] ? !bus.tx_full : !bus.rx_empty);
    end

    // First eligible requester at or after rr_ptr; ineligible ones are simply skipped.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < num_req; k++) begin
            idx = iw'((int'(rr_ptr) + k) % num_req);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign lat_last = (lat_cnt == 3'(read_latency - 1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner   <= '0;
            op_write <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            state   <= state_d;
            lat_cnt <= (state == CAPTURE) ? lat_cnt + 3'd1 : 3'd0;
            if (issue_d) begin
                winner   <= pick;
                op_write <= bus.req_write[pick];
            end
            if (state == DONE)
                rr_ptr <= (winner == iw'(num_req - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found) state_d = ISSUE;
            ISSUE:   state_d = op_write ? DONE : CAPTURE;
            CAPTURE: if (lat_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        issue_d = (state == IDLE) && found;
        we_d    = issue_d && bus.req_write[pick];
        re_d    = issue_d && !bus.req_write[pick];
        addr_d  = idle_address;
        if (we_d)      addr_d = write_address;
        else if (re_d) addr_d = read_address;
        wdata_d = we_d ? wdata_arr[pick] : '0;
        ack_d   = '0;
        if (state_d == DONE) ack_d[winner] = 1'b1;
        rdata_d = (state == CAPTURE && lat_last) ? bus.bus_rdata : '0;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ack_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= idle_address;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack            = ack_q;
    assign bus.rdata          = rdata_q;
    assign bus.bus_wdata      = wdata_q;
    assign bus.active_address = addr_q;
    assign bus.write_enable   = we_q;
    assign bus.read_enable    = re_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_buff_uart_scheduler.sv
// Directed bench for buff_uart_scheduler: write, read with latency 2, round robin,
// FIFO-status blocking and reset in the middle of a read.
module tb_buff_uart_scheduler;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    buff_uart_scheduler_if #(.width(8), .address_width(4), .num_req(4)) bus_if ();

    buff_uart_scheduler #(
        .width(8), .address_width(4), .num_req(4),
        .write_address(4'h1), .read_address(4'h2), .idle_address(4'hF),
        .read_latency(2)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task tick;
        @(posedge clock);
        #1;
    endtask

    task do_reset;
        bus_if.req       = '0;
        bus_if.req_write = '0;
        bus_if.req_wdata = '0;
        bus_if.tx_full   = 1'b0;
        bus_if.rx_empty  = 1'b0;
        bus_if.bus_rdata = '0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task test_reset;
        do_reset();
        tests++; if (bus_if.ack !== 4'b0000) begin fails++; $display("FAIL rst_ack: got %b exp 0000", bus_if.ack); end
        tests++; if (bus_if.rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h exp 00", bus_if.rdata); end
        tests++; if (bus_if.active_address !== 4'hF) begin fails++; $display("FAIL rst_addr: got %h exp F", bus_if.active_address); end
        tests++; if ({bus_if.write_enable, bus_if.read_enable, bus_if.busy} !== 3'b000) begin fails++; $display("FAIL rst_strobes: got we/re/busy %b exp 000", {bus_if.write_enable, bus_if.read_enable, bus_if.busy}); end
        tests++; if (bus_if.bus_wdata !== 8'h00) begin fails++; $display("FAIL rst_wdata: got %h exp 00", bus_if.bus_wdata); end
        tick();
        tests++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy: got %b exp 0", bus_if.busy); end
    endtask

    task test_single_write;
        do_reset();
        bus_if.req       = 4'b0100;
        bus_if.req_write = 4'b0100;
        bus_if.req_wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        tick();
        tests++; if ({bus_if.write_enable, bus_if.read_enable} !== 2'b10) begin fails++; $display("FAIL wr_strobe: got we/re %b exp 10", {bus_if.write_enable, bus_if.read_enable}); end
        tests++; if (bus_if.active_address !== 4'h1) begin fails++; $display("FAIL wr_addr: got %h exp 1", bus_if.active_address); end
        tests++; if (bus_if.bus_wdata !== 8'hA5) begin fails++; $display("FAIL wr_wdata: got %h exp A5", bus_if.bus_wdata); end
        tests++; if (bus_if.ack !== 4'b0000 || bus_if.busy !== 1'b1) begin fails++; $display("FAIL wr_issue_ack_busy: got ack %b busy %b exp 0000 1", bus_if.ack, bus_if.busy); end
        tick();
        tests++; if (bus_if.ack !== 4'b0100) begin fails++; $display("FAIL wr_ack: got %b exp 0100", bus_if.ack); end
        tests++; if ({bus_if.write_enable, bus_if.read_enable} !== 2'b00 || bus_if.active_address !== 4'hF) begin fails++; $display("FAIL wr_done_bus: got we/re %b addr %h exp 00 F", {bus_if.write_enable, bus_if.read_enable}, bus_if.active_address); end
        tests++; if (bus_if.rdata !== 8'h00) begin fails++; $display("FAIL wr_rdata: got %h exp 00", bus_if.rdata); end
        bus_if.req = '0;
        tick();
        tests++; if (bus_if.ack !== 4'b0000 || bus_if.busy !== 1'b0) begin fails++; $display("FAIL wr_after: got ack %b busy %b exp 0000 0", bus_if.ack, bus_if.busy); end
    endtask

    task test_read;
        do_reset();
        bus_if.req       = 4'b0001;
        bus_if.req_write = 4'b0000;
        tick();
        tests++; if ({bus_if.write_enable, bus_if.read_enable} !== 2'b01) begin fails++; $display("FAIL rd_strobe: got we/re %b exp 01", {bus_if.write_enable, bus_if.read_enable}); end
        tests++; if (bus_if.active_address !== 4'h2 || bus_if.bus_wdata !== 8'h00) begin fails++; $display("FAIL rd_addr: got addr %h wdata %h exp 2 00", bus_if.active_address, bus_if.bus_wdata); end
        bus_if.bus_rdata = 8'h77;
        tick();
        tests++; if (bus_if.read_enable !== 1'b0 || bus_if.active_address !== 4'hF || bus_if.ack !== 4'b0000) begin fails++; $display("FAIL rd_cap1: got re %b addr %h ack %b exp 0 F 0000", bus_if.read_enable, bus_if.active_address, bus_if.ack); end
        tick();
        bus_if.bus_rdata = 8'h3C;
        tests++; if (bus_if.read_enable !== 1'b0 || bus_if.ack !== 4'b0000 || bus_if.busy !== 1'b1) begin fails++; $display("FAIL rd_cap2: got re %b ack %b busy %b exp 0 0000 1", bus_if.read_enable, bus_if.ack, bus_if.busy); end
        tick();
        tests++; if (bus_if.ack !== 4'b0001) begin fails++; $display("FAIL rd_ack: got %b exp 0001", bus_if.ack); end
        tests++; if (bus_if.rdata !== 8'h3C) begin fails++; $display("FAIL rd_rdata: got %h exp 3C", bus_if.rdata); end
        bus_if.req       = '0;
        bus_if.bus_rdata = '0;
        tick();
        tests++; if (bus_if.ack !== 4'b0000 || bus_if.rdata !== 8'h00) begin fails++; $display("FAIL rd_after: got ack %b rdata %h exp 0000 00", bus_if.ack, bus_if.rdata); end
    endtask

    task test_round_robin;
        logic [3:0] exp_ack;
        logic [7:0] exp_data;
        do_reset();
        bus_if.req       = 4'b1111;
        bus_if.req_write = 4'b1111;
        bus_if.req_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int g = 0; g < 6; g++) begin
            exp_ack  = 4'b0001 << (g % 4);
            exp_data = 8'h10 + 8'(g % 4);
            tick();
            tests++; if (bus_if.write_enable !== 1'b1 || bus_if.bus_wdata !== exp_data) begin fails++; $display("FAIL rr_issue%0d: got we %b wdata %h exp 1 %h", g, bus_if.write_enable, bus_if.bus_wdata, exp_data); end
            tick();
            tests++; if (bus_if.ack !== exp_ack) begin fails++; $display("FAIL rr_ack%0d: got %b exp %b", g, bus_if.ack, exp_ack); end
            if (g == 5) bus_if.req = '0;
            tick();
            tests++; if (bus_if.ack !== 4'b0000 || bus_if.busy !== 1'b0) begin fails++; $display("FAIL rr_idle%0d: got ack %b busy %b exp 0000 0", g, bus_if.ack, bus_if.busy); end
        end
        tick();
        tests++; if (bus_if.busy !== 1'b0 || bus_if.write_enable !== 1'b0) begin fails++; $display("FAIL rr_end: got busy %b we %b exp 0 0", bus_if.busy, bus_if.write_enable); end
    endtask

    task test_blocking;
        do_reset();
        bus_if.tx_full   = 1'b1;
        bus_if.req       = 4'b1010;
        bus_if.req_write = 4'b0010;
        bus_if.req_wdata = {8'h00, 8'h00, 8'h55, 8'h00};
        tick();
        tests++; if ({bus_if.write_enable, bus_if.read_enable} !== 2'b01 || bus_if.active_address !== 4'h2) begin fails++; $display("FAIL blk_rd_issue: got we/re %b addr %h exp 01 2", {bus_if.write_enable, bus_if.read_enable}, bus_if.active_address); end
        tick();
        tick();
        bus_if.bus_rdata = 8'h99;
        tick();
        tests++; if (bus_if.ack !== 4'b1000 || bus_if.rdata !== 8'h99) begin fails++; $display("FAIL blk_rd_ack: got ack %b rdata %h exp 1000 99", bus_if.ack, bus_if.rdata); end
        bus_if.req[3] = 1'b0;
        tick();
        tick();
        tests++; if (bus_if.busy !== 1'b0 || bus_if.ack !== 4'b0000 || bus_if.write_enable !== 1'b0) begin fails++; $display("FAIL blk_held: got busy %b ack %b we %b exp 0 0000 0", bus_if.busy, bus_if.ack, bus_if.write_enable); end
        bus_if.tx_full = 1'b0;
        tick();
        tests++; if (bus_if.write_enable !== 1'b1 || bus_if.bus_wdata !== 8'h55) begin fails++; $display("FAIL blk_wr_issue: got we %b wdata %h exp 1 55", bus_if.write_enable, bus_if.bus_wdata); end
        bus_if.tx_full = 1'b1;
        tick();
        tests++; if (bus_if.ack !== 4'b0010) begin fails++; $display("FAIL blk_wr_ack: got %b exp 0010", bus_if.ack); end
        bus_if.req     = '0;
        bus_if.tx_full = 1'b0;
        tick();
    endtask

    task test_reset_mid_read;
        do_reset();
        bus_if.req       = 4'b0010;
        bus_if.req_write = 4'b0011;
        bus_if.req_wdata = {8'h00, 8'h00, 8'h11, 8'hC3};
        tick();
        tick();
        tests++; if (bus_if.ack !== 4'b0010) begin fails++; $display("FAIL mr_pre_ack: got %b exp 0010", bus_if.ack); end
        bus_if.req = '0;
        tick();
        bus_if.req = 4'b0100;
        tick();
        tests++; if (bus_if.read_enable !== 1'b1) begin fails++; $display("FAIL mr_rd_issue: got re %b exp 1", bus_if.read_enable); end
        tick();
        bus_if.req       = 4'b0101;
        bus_if.bus_rdata = 8'hAB;
        resetn           = 1'b0;
        tick();
        tests++; if (bus_if.ack !== 4'b0000 || bus_if.rdata !== 8'h00) begin fails++; $display("FAIL mr_rst_ack: got ack %b rdata %h exp 0000 00", bus_if.ack, bus_if.rdata); end
        tests++; if (bus_if.active_address !== 4'hF || bus_if.busy !== 1'b0 || bus_if.read_enable !== 1'b0) begin fails++; $display("FAIL mr_rst_bus: got addr %h busy %b re %b exp F 0 0", bus_if.active_address, bus_if.busy, bus_if.read_enable); end
        resetn = 1'b1;
        tick();
        tests++; if (bus_if.write_enable !== 1'b1 || bus_if.bus_wdata !== 8'hC3 || bus_if.active_address !== 4'h1) begin fails++; $display("FAIL mr_reserve: got we %b wdata %h addr %h exp 1 C3 1", bus_if.write_enable, bus_if.bus_wdata, bus_if.active_address); end
        tick();
        tests++; if (bus_if.ack !== 4'b0001) begin fails++; $display("FAIL mr_ack: got %b exp 0001", bus_if.ack); end
        bus_if.req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_blocking();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
